// File: rtl/link_bringup_sequencer.sv
// Link bring-up sequencer: owns the transmitter and receiver resets, releases
// the receiver first and then the transmitter, waits for receiver sync,
// watches the established link, and retries with a backoff on timeout, sync
// loss or too many receive errors. All outputs come straight from flops.
module link_bringup_sequencer #(
    parameter int RX_RST_CYCLES  = 4,
    parameter int TX_RST_CYCLES  = 8,
    parameter int SYNC_TIMEOUT   = 256,
    parameter int ERR_LIMIT      = 4,
    parameter int BACKOFF_CYCLES = 16,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       rx_sync_i,
    input  logic       rx_err_i,
    output logic       tx_rst_o,
    output logic       rx_rst_o,
    output logic       tx_en_o,
    output logic       link_up_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);

    // Timer values on the last cycle of each timed state: a state entered on
    // edge E with timer 0 leaves on edge E+N when the timer reads N-1.
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BO_LAST   = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(ERR_LIMIT);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_RST,
        S_TX_RST,
        S_WAIT_SYNC,
        S_LINK_UP,
        S_BACKOFF,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       retry_cnt_q, retry_cnt_d;
    logic             tx_rst_q, tx_rst_d;
    logic             rx_rst_q, rx_rst_d;
    logic             tx_en_q, tx_en_d;
    logic             link_up_q, link_up_d;
    logic             fail_q, fail_d;
    logic [ERR_W-1:0] err_next;
    logic             retry_req;

    // Error counter increment that sticks at the limit instead of wrapping.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt,
                                                     input logic             pulse);
        if (pulse && (cnt != ERR_MAX)) begin
            return cnt + ERR_W'(1);
        end
        return cnt;
    endfunction

    // Next-state, timer, error count and retry count.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + CNT_W'(1);
        err_cnt_d   = err_cnt_q;
        retry_cnt_d = retry_cnt_q;
        retry_req   = 1'b0;
        err_next    = err_sat_inc(err_cnt_q, rx_err_i);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_RX_RST;
                    retry_cnt_d = 2'd0;
                end
            end
            S_RX_RST: begin
                if (timer_q == RX_LAST) state_d = S_TX_RST;
            end
            S_TX_RST: begin
                if (timer_q == TX_LAST) state_d = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                // Sync arriving on the timeout edge still counts as success.
                if (rx_sync_i) begin
                    state_d   = S_LINK_UP;
                    err_cnt_d = '0;
                end else if (timer_q == SYNC_LAST) begin
                    retry_req = 1'b1;
                end
            end
            S_LINK_UP: begin
                err_cnt_d = err_next;
                // Sync loss and error limit on the same edge are one retry.
                if (!rx_sync_i || (err_next == ERR_MAX)) retry_req = 1'b1;
            end
            S_BACKOFF: begin
                if (timer_q == BO_LAST) state_d = S_RX_RST;
            end
            S_FAIL: begin
                if (start_i) begin
                    state_d     = S_RX_RST;
                    retry_cnt_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retry_req) begin
            if (retry_cnt_q == RETRY_MAX) begin
                state_d = S_FAIL;
            end else begin
                retry_cnt_d = retry_cnt_q + 2'd1;
                state_d     = S_BACKOFF;
            end
        end

        // Abort overrides everything, including a simultaneous start.
        if (stop_i) begin
            state_d     = S_IDLE;
            retry_cnt_d = 2'd0;
        end

        // The timer restarts from zero on every state entry and idles at zero
        // in the untimed states.
        if ((state_d != state_q) || (state_d == S_IDLE) ||
            (state_d == S_LINK_UP) || (state_d == S_FAIL)) begin
            timer_d = '0;
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        tx_rst_d  = 1'b1;
        rx_rst_d  = 1'b1;
        tx_en_d   = 1'b0;
        link_up_d = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            S_TX_RST: begin
                rx_rst_d = 1'b0;
            end
            S_WAIT_SYNC: begin
                tx_rst_d = 1'b0;
                rx_rst_d = 1'b0;
                tx_en_d  = 1'b1;
            end
            S_LINK_UP: begin
                tx_rst_d  = 1'b0;
                rx_rst_d  = 1'b0;
                tx_en_d   = 1'b1;
                link_up_d = 1'b1;
            end
            S_FAIL: begin
                fail_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            err_cnt_q   <= '0;
            retry_cnt_q <= 2'd0;
            tx_rst_q    <= 1'b1;
            rx_rst_q    <= 1'b1;
            tx_en_q     <= 1'b0;
            link_up_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_cnt_q   <= err_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            tx_rst_q    <= tx_rst_d;
            rx_rst_q    <= rx_rst_d;
            tx_en_q     <= tx_en_d;
            link_up_q   <= link_up_d;
            fail_q      <= fail_d;
        end
    end

    assign tx_rst_o    = tx_rst_q;
    assign rx_rst_o    = rx_rst_q;
    assign tx_en_o     = tx_en_q;
    assign link_up_o   = link_up_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_link_bringup_sequencer.sv
// Testbench for link_bringup_sequencer. Stimulus queues cycle-stamped expected
// output vectors {tx_rst, rx_rst, tx_en, link_up, fail, retry_cnt[1:0]}; a
// monitor on the falling edge pops and compares each entry on its cycle.
module tb_link_bringup_sequencer;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       stop_i;
    logic       rx_sync_i;
    logic       rx_err_i;
    logic       tx_rst_o;
    logic       rx_rst_o;
    logic       tx_en_o;
    logic       link_up_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;

    link_bringup_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .rx_sync_i  (rx_sync_i),
        .rx_err_i   (rx_err_i),
        .tx_rst_o   (tx_rst_o),
        .rx_rst_o   (rx_rst_o),
        .tx_en_o    (tx_en_o),
        .link_up_o  (link_up_o),
        .fail_o     (fail_o),
        .retry_cnt_o(retry_cnt_o)
    );

    typedef struct {
        int         cyc;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_mis  = 0;
    logic [6:0] outv;

    assign outv = {tx_rst_o, rx_rst_o, tx_en_o, link_up_o, fail_o, retry_cnt_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected vectors per state.
    function automatic logic [6:0] v_rst(input logic [1:0] rc);
        return {5'b11000, rc};
    endfunction
    function automatic logic [6:0] v_txr(input logic [1:0] rc);
        return {5'b10000, rc};
    endfunction
    function automatic logic [6:0] v_wait(input logic [1:0] rc);
        return {5'b00100, rc};
    endfunction
    function automatic logic [6:0] v_up(input logic [1:0] rc);
        return {5'b00110, rc};
    endfunction
    function automatic logic [6:0] v_fail();
        return 7'b1100111;
    endfunction

    task automatic expect_at(input int c, input logic [6:0] val, input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Reset release timing for one attempt starting (RX_RST entered) at cycle s.
    task automatic push_attempt(input int s, input logic [1:0] rc);
        expect_at(s,      v_rst(rc),  "rx_rst_enter");
        expect_at(s + 3,  v_rst(rc),  "rx_rst_last");
        expect_at(s + 4,  v_txr(rc),  "rx_release");
        expect_at(s + 11, v_txr(rc),  "tx_rst_last");
        expect_at(s + 12, v_wait(rc), "tx_release");
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic err_pulses3(input logic [1:0] rc);
        int c;
        for (int k = 0; k < 3; k++) begin
            rx_err_i = 1'b1;
            @(negedge clk);
            rx_err_i = 1'b0;
            @(negedge clk);
        end
        c = cyc;
        expect_at(c + 1, v_up(rc), "err3_keep_link");
        expect_at(c + 3, v_up(rc), "err3_keep_link_hold");
        goto(c + 4);
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc || outv !== e.val) begin
                n_mis++;
                $display("FAIL %s: cycle %0d outputs %b, required %b at cycle %0d",
                         e.name, cyc, outv, e.val, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending",
                 sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e;
        int c;
        int s;
        rst       = 1'b1;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        rx_sync_i = 1'b0;
        rx_err_i  = 1'b0;
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, v_rst(0), "reset_state");
        @(negedge clk);
        rst = 1'b0;
        expect_at(cyc + 2, v_rst(0), "idle_after_reset");
        repeat (3) @(negedge clk);

        // start and stop together: stop wins, stay in IDLE
        c = cyc;
        start_i = 1'b1;
        stop_i  = 1'b1;
        expect_at(c + 1, v_rst(0), "start_stop_idle");
        expect_at(c + 8, v_rst(0), "start_stop_still_idle");
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        goto(c + 9);

        // nominal bring-up, sync sampled 20 cycles after start
        e = cyc + 1;
        start_i = 1'b1;
        push_attempt(e, 2'd0);
        expect_at(e + 19, v_wait(0), "nom_before_sync");
        expect_at(e + 20, v_up(0),   "nom_link_up");
        expect_at(e + 25, v_up(0),   "nom_link_hold");
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 19);
        rx_sync_i = 1'b1;
        goto(e + 26);

        // three errors keep the link, the fourth forces a retry
        err_pulses3(2'd0);
        rx_err_i = 1'b1;
        e = cyc + 1;
        expect_at(e,      v_rst(1), "err4_backoff");
        expect_at(e + 15, v_rst(1), "backoff_last");
        push_attempt(e + 16, 2'd1);
        expect_at(e + 29, v_up(1),  "relink_retry1");
        @(negedge clk);
        rx_err_i = 1'b0;
        goto(e + 30);

        // one-cycle sync loss
        rx_sync_i = 1'b0;
        e = cyc + 1;
        expect_at(e, v_rst(2), "sync_loss_backoff");
        push_attempt(e + 16, 2'd2);
        expect_at(e + 29, v_up(2), "relink_retry2");
        @(negedge clk);
        rx_sync_i = 1'b1;
        goto(e + 30);

        // error limit and sync loss on the same edge count once
        err_pulses3(2'd2);
        rx_err_i  = 1'b1;
        rx_sync_i = 1'b0;
        e = cyc + 1;
        expect_at(e, v_rst(3), "dual_event_one_retry");
        push_attempt(e + 16, 2'd3);
        expect_at(e + 29, v_up(3), "relink_retry3");
        @(negedge clk);
        rx_err_i  = 1'b0;
        rx_sync_i = 1'b1;
        goto(e + 30);

        // retries exhausted
        rx_sync_i = 1'b0;
        e = cyc + 1;
        expect_at(e,     v_fail(), "retries_exhausted");
        expect_at(e + 5, v_fail(), "fail_hold");
        goto(e + 6);

        // restart from FAIL, then stop while waiting for sync
        e = cyc + 1;
        start_i = 1'b1;
        push_attempt(e, 2'd0);
        expect_at(e + 15, v_rst(0), "stop_in_wait_sync");
        expect_at(e + 20, v_rst(0), "stop_idle_hold");
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 14);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        goto(e + 21);

        // sync never arrives: four timed-out attempts then FAIL
        e = cyc + 1;
        start_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = e + 284 * k;
            push_attempt(s, 2'(k));
            expect_at(s + 267, v_wait(2'(k)), "wait_before_timeout");
            if (k < 3) expect_at(s + 268, v_rst(2'(k + 1)), "timeout_backoff");
            else       expect_at(s + 268, v_fail(),         "timeout_fail");
        end
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 284 * 3 + 269);

        // sync sampled on the timeout edge wins
        e = cyc + 1;
        start_i = 1'b1;
        push_attempt(e, 2'd0);
        expect_at(e + 267, v_wait(0), "wait_last_cycle");
        expect_at(e + 268, v_up(0),   "sync_at_timeout_wins");
        expect_at(e + 270, v_up(0),   "sync_at_timeout_hold");
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 267);
        rx_sync_i = 1'b1;
        goto(e + 271);

        // stop from LINK_UP, restart, async reset in the middle of TX_RST
        stop_i = 1'b1;
        expect_at(cyc + 1, v_rst(0), "stop_from_link");
        @(negedge clk);
        stop_i    = 1'b0;
        rx_sync_i = 1'b0;
        e = cyc + 1;
        start_i = 1'b1;
        expect_at(e,     v_rst(0), "restart_rx_rst");
        expect_at(e + 4, v_txr(0), "restart_tx_rst");
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 6);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outv !== v_rst(0)) begin
            n_mis++;
            $display("FAIL async_reset_immediate: outputs %b, required %b", outv, v_rst(0));
        end
        expect_at(cyc + 1, v_rst(0), "async_reset_held");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_at(cyc + 3, v_rst(0), "idle_after_async");
        goto(cyc + 4);

        // clean restart after async reset
        e = cyc + 1;
        start_i = 1'b1;
        push_attempt(e, 2'd0);
        @(negedge clk);
        start_i = 1'b0;
        goto(e + 14);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: %0d expectations unconsumed, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
